// File: rtl/rr_decode_arbiter_if.sv
// rr_decode_arbiter_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;
  modport master(output req, done, input grant, grant_idx, busy, timeout);
  modport slave(input req, done, output grant, grant_idx, busy, timeout);
endinterface

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 8-way round-robin arbiter with decoded one-hot grant and hold-time watchdog
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic               clk,
  input logic               rst,
  rr_decode_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [HOLD_W-1:0] hold_lim = HOLD_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  state_t            state;
  logic [2:0]        ptr;
  logic [2:0]        sel;
  logic [HOLD_W-1:0] cnt;
  logic              rel_norm;
  logic              wd;
  // Scan from the far end so the index closest to ptr is written last and wins.
  always_comb begin
    sel = ptr;
    for (int i = 7; i >= 0; i--)
      if (bus.req[ptr + 3'(i)]) sel = ptr + 3'(i);
  end
  assign rel_norm = bus.done || !bus.req[bus.grant_idx];
  assign wd       = (MAX_HOLD != 0) && (cnt == hold_lim);
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.grant     <= 8'h00;
      bus.grant_idx <= 3'd0;
      bus.busy      <= 1'b0;
      bus.timeout   <= 1'b0;
      ptr           <= 3'd0;
      cnt           <= '0;
    end else begin
      bus.timeout <= 1'b0;
      if (state == IDLE) begin
        if (bus.req != 8'h00) begin
          bus.grant_idx <= sel;
          bus.grant     <= 8'h01 << sel;
          bus.busy      <= 1'b1;
          cnt           <= '0;
          state         <= GRANT;
        end
      end else begin
        cnt <= cnt + HOLD_W'(cnt != '1);
        if (rel_norm || wd) begin
          bus.grant   <= 8'h00;
          bus.busy    <= 1'b0;
          bus.timeout <= wd && !rel_norm;
          ptr         <= bus.grant_idx + 3'd1;
          state       <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed plan scenarios plus random traffic against a behavioural model
module tb_rr_decode_arbiter;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  rr_decode_arbiter_if bus ();
  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit   m_busy = 0;
  int   m_idx = 0;
  int   m_ptr = 0;
  int   m_held = 0;
  bit   m_to = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask
  // Reference: holder, cycles held so far, and next priority index as plain integers.
  task automatic model_step(input logic r, input logic [7:0] q, input logic d);
    bit normal;
    bit dog;
    if (r) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 7; k >= 0; k--)
        if (q[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
      if (q != 0) begin
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      normal = d || !q[m_idx];
      dog    = MAX_HOLD != 0 && m_held == MAX_HOLD;
      m_to   = dog && !normal;
      if (normal || dog) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
      end else m_held++;
    end
  endtask
  task automatic cyc(input logic r, input logic [7:0] q, input logic d);
    logic [7:0] eg;
    rst = r; bus.req = q; bus.done = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
    eg = m_busy ? 8'h01 << m_idx : 8'h00;
    check("grant", 32'(bus.grant), 32'(eg));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("timeout", 32'(bus.timeout), 32'(m_to));
    if (m_busy) check("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
    check("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
  endtask
  initial begin
    bus.req = 8'h00; bus.done = 1'b0;
    // 1: reset then single request, done on the third grant cycle
    cyc(1, 8'h00, 0); cyc(1, 8'h00, 0);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_idx", 32'(bus.grant_idx), 32'h0);
    cyc(0, 8'h10, 0);
    check("t1_grant", 32'(bus.grant), 32'h10);
    check("t1_idx", 32'(bus.grant_idx), 32'd4);
    cyc(0, 8'h10, 0); cyc(0, 8'h10, 1);
    check("t1_release", 32'(bus.busy), 32'd0);
    cyc(0, 8'hFF, 0);
    check("t1_ptr5", 32'(bus.grant_idx), 32'd5);
    // 2: fairness with all requesting
    cyc(1, 8'h00, 0);
    for (int k = 0; k < 9; k++) begin
      cyc(0, 8'hFF, 0);
      check("t2_seq", 32'(bus.grant_idx), 32'(k % 8));
      cyc(0, 8'hFF, 1);
      check("t2_idle", 32'(bus.busy), 32'd0);
    end
    // 3: wrap from pointer 7 and skip
    cyc(1, 8'h00, 0);
    cyc(0, 8'h40, 0); cyc(0, 8'h40, 1);
    cyc(0, 8'h05, 0);
    check("t3_wrap", 32'(bus.grant), 32'h01);
    cyc(0, 8'h05, 1);
    cyc(0, 8'h05, 0);
    check("t3_skip", 32'(bus.grant), 32'h04);
    // 4: release by dropping the request
    cyc(1, 8'h00, 0);
    cyc(0, 8'h08, 0);
    repeat (3) cyc(0, 8'h08, 0);
    cyc(0, 8'h00, 0);
    check("t4_drop", 32'(bus.grant), 32'h0);
    check("t4_to", 32'(bus.timeout), 32'd0);
    cyc(0, 8'hFF, 0);
    check("t4_ptr4", 32'(bus.grant_idx), 32'd4);
    // 5: watchdog, then the same with done on the limit cycle
    cyc(1, 8'h00, 0);
    cyc(0, 8'h02, 0);
    repeat (15) begin
      cyc(0, 8'h02, 0);
      check("t5_hold", 32'(bus.grant), 32'h02);
    end
    cyc(0, 8'h02, 0);
    check("t5_forced", 32'(bus.grant), 32'h0);
    check("t5_pulse", 32'(bus.timeout), 32'd1);
    cyc(0, 8'h02, 0);
    check("t5_regrant", 32'(bus.grant), 32'h02);
    check("t5_pulse_end", 32'(bus.timeout), 32'd0);
    repeat (15) cyc(0, 8'h02, 0);
    cyc(0, 8'h02, 1);
    check("t5_done_wins", 32'(bus.timeout), 32'd0);
    check("t5_done_rel", 32'(bus.busy), 32'd0);
    // 6: reset mid-grant
    cyc(1, 8'h00, 0);
    cyc(0, 8'h20, 0); cyc(0, 8'h20, 0);
    cyc(1, 8'h20, 0);
    check("t6_rst", 32'(bus.busy), 32'd0);
    cyc(0, 8'h21, 0);
    check("t6_ptr0", 32'(bus.grant_idx), 32'd0);
    // random traffic: sticky requests so the watchdog is reachable
    begin
      logic [7:0] q;
      q = 8'($urandom);
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 7) == 0) q = 8'($urandom);
        cyc($urandom_range(0, 199) == 0, q, $urandom_range(0, 11) == 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
